// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int WORD_BYTES = 4;

  typedef logic [31:0] addr_t;

  function automatic addr_t word_align(input addr_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch.sv
// Instruction fetch unit: redirect-driven word reads with optional sequential
// prefetch of MAX_BURST words, enabled by defining FETCH_PREFETCH_EN.
module fetch
  import fetch_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] program_counter,
  input  logic        program_counter_valid,
  output logic        bus_read_vaild,
  output logic [31:0] bus_read_address,
  input  logic        bus_read_ready,
  input  logic [31:0] bus_read_data,
  output logic [31:0] instruction,
  output logic        instruction_ready
);

  localparam logic [7:0] BURST = 8'(MAX_BURST);

  state_e     state_q;
  logic       vld_q;
  addr_t      addr_q;
  addr_t      pc_q;
  logic [31:0] instr_q;
  logic       irdy_q;
  logic [7:0] cnt_q;

  logic       hs;
  addr_t      pc_aln;
  logic [7:0] cnt_d;
  logic       more;

  assign hs     = vld_q & bus_read_ready;
  assign pc_aln = word_align(program_counter);
  assign cnt_d  = cnt_q - 8'd1;
`ifdef FETCH_PREFETCH_EN
  assign more   = (cnt_d != 8'd0);
`else
  assign more   = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
      addr_q  <= '0;
      pc_q    <= '0;
      instr_q <= '0;
      irdy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      irdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (program_counter_valid) begin
            vld_q   <= 1'b1;
            addr_q  <= pc_aln;
            cnt_q   <= BURST;
            state_q <= READ;
          end
        end
        READ: begin
          if (hs && program_counter_valid) begin
            // completing word belongs to the old stream: drop it
            addr_q <= pc_aln;
            cnt_q  <= BURST;
          end else if (hs) begin
            instr_q <= bus_read_data;
            irdy_q  <= 1'b1;
            cnt_q   <= cnt_d;
            if (more) begin
              addr_q <= addr_q + addr_t'(WORD_BYTES);
            end else begin
              vld_q   <= 1'b0;
              state_q <= IDLE;
            end
          end else if (program_counter_valid) begin
            pc_q    <= pc_aln;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (hs) begin
            addr_q  <= program_counter_valid ? pc_aln : pc_q;
            cnt_q   <= BURST;
            state_q <= READ;
          end else if (program_counter_valid) begin
            pc_q <= pc_aln;
          end
        end
        default: begin
          vld_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_read_vaild    = vld_q;
  assign bus_read_address  = addr_q;
  assign instruction       = instr_q;
  assign instruction_ready = irdy_q;

endmodule

// File: tb/tb_fetch.sv
// Directed vector bench for the fetch unit; expectations follow FETCH_PREFETCH_EN.
module tb_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] program_counter = '0;
  logic        program_counter_valid = 1'b0;
  logic        bus_read_vaild;
  logic [31:0] bus_read_address;
  logic        bus_read_ready = 1'b0;
  logic [31:0] bus_read_data = '0;
  logic [31:0] instruction;
  logic        instruction_ready;

  int checks = 0;
  int errors = 0;

  fetch #(.MAX_BURST(8)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .program_counter       (program_counter),
    .program_counter_valid (program_counter_valid),
    .bus_read_vaild        (bus_read_vaild),
    .bus_read_address      (bus_read_address),
    .bus_read_ready        (bus_read_ready),
    .bus_read_data         (bus_read_data),
    .instruction           (instruction),
    .instruction_ready     (instruction_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        pcv;
    logic [31:0] pc;
    logic        rdy;
    logic [31:0] data;
    logic        e_vld;
    logic [31:0] e_addr;
    logic        e_irdy;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic pcv, input logic [31:0] pc, input logic rdy,
                     input logic [31:0] data, input logic vld, input logic [31:0] addr,
                     input logic irdy, input logic [31:0] instr);
    vec_t v;
    v.pcv = pcv; v.pc = pc; v.rdy = rdy; v.data = data;
    v.e_vld = vld; v.e_addr = addr; v.e_irdy = irdy; v.e_instr = instr;
    vq.push_back(v);
  endtask

  task automatic run_vectors(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      program_counter_valid = vq[i].pcv;
      program_counter       = vq[i].pc;
      bus_read_ready        = vq[i].rdy;
      bus_read_data         = vq[i].data;
      @(posedge clock); #1;
      chk($sformatf("%s[%0d].vld", tag, i),   {31'd0, bus_read_vaild},    {31'd0, vq[i].e_vld});
      chk($sformatf("%s[%0d].addr", tag, i),  bus_read_address,           vq[i].e_addr);
      chk($sformatf("%s[%0d].irdy", tag, i),  {31'd0, instruction_ready}, {31'd0, vq[i].e_irdy});
      chk($sformatf("%s[%0d].instr", tag, i), instruction,                vq[i].e_instr);
    end
    vq.delete();
    program_counter_valid = 1'b0;
    bus_read_ready        = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".vld"},   {31'd0, bus_read_vaild},    32'd0);
    chk({tag, ".addr"},  bus_read_address,           32'd0);
    chk({tag, ".irdy"},  {31'd0, instruction_ready}, 32'd0);
    chk({tag, ".instr"}, instruction,                32'd0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1 check_zero(tag);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000 ns");
    $fatal(1);
  end

  initial begin
    #2 check_zero("por");
    repeat (2) @(posedge clock);
    // release reset with a redirect already pending; the first edge must take it
    #1 reset = 1'b1;

    // stalled read then a burst from 0x20; the second PC cycle is a redirect to the same address
    add(1, 32'h20, 0, 0, 1, 32'h20, 0, 0);
    add(1, 32'h20, 0, 0, 1, 32'h20, 0, 0);
    add(0, 0,      0, 0, 1, 32'h20, 0, 0);
    add(0, 0,      0, 0, 1, 32'h20, 0, 0);
    add(0, 0, 1, 32'h0001_1011, 1, 32'h20, 0, 0);
`ifdef FETCH_PREFETCH_EN
    for (int k = 1; k <= 7; k++)
      add(0, 0, 1, 32'h0001_1011, 1, 32'h20 + 32'(4 * k), 1, 32'h0001_1011);
    add(0, 0, 1, 32'h0001_1011, 0, 32'h3C, 1, 32'h0001_1011);
    add(0, 0, 1, 32'h0001_1011, 0, 32'h3C, 0, 32'h0001_1011);
`else
    add(0, 0, 1, 32'h0001_1011, 0, 32'h20, 1, 32'h0001_1011);
    add(0, 0, 1, 32'h0001_1011, 0, 32'h20, 0, 32'h0001_1011);
`endif
    run_vectors("burst");

    do_reset("rst1");
    // unaligned PC, drain with last-wins redirect, same-cycle redirect on completion
    add(1, 32'h103, 0, 0, 1, 32'h100, 0, 0);
`ifdef FETCH_PREFETCH_EN
    add(0, 0, 1, 32'hAAAA, 1, 32'h104, 1, 32'hAAAA);
    add(1, 32'h200, 0, 0,   1, 32'h104, 0, 32'hAAAA);
    add(1, 32'h300, 0, 0,   1, 32'h104, 0, 32'hAAAA);
    add(0, 0, 1, 32'hBBBB,  1, 32'h300, 0, 32'hAAAA);
    add(1, 32'h401, 1, 32'hCCCC, 1, 32'h400, 0, 32'hAAAA);
    add(0, 0, 1, 32'hDDDD,  1, 32'h404, 1, 32'hDDDD);
`else
    add(0, 0, 1, 32'hAAAA, 0, 32'h100, 1, 32'hAAAA);
    add(1, 32'h24,  0, 0,   1, 32'h24, 0, 32'hAAAA);
    add(1, 32'h200, 0, 0,   1, 32'h24, 0, 32'hAAAA);
    add(1, 32'h300, 0, 0,   1, 32'h24, 0, 32'hAAAA);
    add(0, 0, 1, 32'hBBBB,  1, 32'h300, 0, 32'hAAAA);
    add(1, 32'h401, 1, 32'hCCCC, 1, 32'h400, 0, 32'hAAAA);
    add(0, 0, 1, 32'hDDDD,  0, 32'h400, 1, 32'hDDDD);
    add(0, 0, 1, 32'hDDDD,  0, 32'h400, 0, 32'hDDDD);
`endif
    run_vectors("redir");

    do_reset("rst2");
`ifdef FETCH_PREFETCH_EN
    // address wrap across 2^32
    add(1, 32'hFFFF_FFF8, 0, 0, 1, 32'hFFFF_FFF8, 0, 0);
    add(0, 0, 1, 32'h1, 1, 32'hFFFF_FFFC, 1, 32'h1);
    add(0, 0, 1, 32'h2, 1, 32'h0000_0000, 1, 32'h2);
    add(0, 0, 1, 32'h3, 1, 32'h0000_0004, 1, 32'h3);
    add(1, 32'h80, 0, 0, 1, 32'h4, 0, 32'h3);
`else
    // single word per redirect; ready while idle is ignored
    add(1, 32'h40, 1, 32'h9, 1, 32'h40, 0, 0);
    add(0, 0, 1, 32'h5, 0, 32'h40, 1, 32'h5);
    add(0, 0, 1, 32'h6, 0, 32'h40, 0, 32'h5);
    add(0, 0, 1, 32'h7, 0, 32'h40, 0, 32'h5);
    add(1, 32'h80, 0, 0, 1, 32'h80, 0, 32'h5);
`endif
    run_vectors("seq");

    // reset mid-transaction with a completing handshake on the bus
    program_counter_valid = 1'b0;
    bus_read_ready = 1'b1;
    bus_read_data  = 32'hEEEE_EEEE;
    #2 reset = 1'b0;
    #1 check_zero("midrst");
    @(posedge clock); #1;
    check_zero("midrst_hold");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk($sformatf("post[%0d].irdy", i), {31'd0, instruction_ready}, 32'd0);
      chk($sformatf("post[%0d].vld", i),  {31'd0, bus_read_vaild},    32'd0);
      chk($sformatf("post[%0d].instr", i), instruction,               32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter MAX_BURST, default 8: the number of words fetched per redirect when prefetch is compiled in; legal range 1..255.
REQ-002 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port program_counter, input, 32 bits: the redirect target byte address.
REQ-005 Port program_counter_valid, input, 1 bit: redirect request, sampled on each rising edge.
REQ-006 Port bus_read_vaild, output, 1 bit: read request valid. The spelling is part of the interface.
REQ-007 Port bus_read_address, output, 32 bits: word-aligned read address.
REQ-008 Port bus_read_ready, input, 1 bit: read completes on any rising edge where bus_read_vaild and bus_read_ready are both high.
REQ-009 Port bus_read_data, input, 32 bits: read data, valid in the completing cycle.
REQ-010 Port instruction, output, 32 bits: the most recently delivered fetched word.
REQ-011 Port instruction_ready, output, 1 bit: one-cycle pulse meaning instruction holds a new word.

Function
REQ-012 The FSM SHALL have three states: IDLE, READ and DRAIN.
REQ-013 IDLE with program_counter_valid=1: bus_read_vaild=1 and bus_read_address=program_counter with bits [1:0] cleared, from the next cycle; state goes to READ; the burst count is loaded with MAX_BURST.
REQ-014 In READ, bus_read_vaild and bus_read_address SHALL stay constant until the handshake completes.
REQ-015 On handshake completion in READ without a redirect, the next cycle SHALL have instruction=bus_read_data and instruction_ready=1 for exactly that one cycle.
REQ-016 instruction SHALL hold its value until the next delivery.
REQ-017 After each completion, the burst count SHALL decrement by one.
REQ-018 If the count becomes 0, or prefetch is compiled out, bus_read_vaild SHALL drop next cycle and the state SHALL return to IDLE.
REQ-019 Otherwise (count nonzero, prefetch compiled in), the next request SHALL issue back-to-back: bus_read_vaild stays 1 and the address becomes previous address + 4.
REQ-020 Address increment SHALL wrap modulo 2^32: 0xFFFF_FFFC + 4 = 0x0000_0000.
REQ-021 Redirect in READ while the handshake is not completing: store the new aligned PC and go to DRAIN; the outstanding request stays unchanged.
REQ-022 In DRAIN, on handshake completion: discard the data (no instruction_ready), then issue the stored PC next cycle and return to READ with a fresh burst count.
REQ-023 A further redirect while in DRAIN SHALL overwrite the stored PC (last one wins).
REQ-024 Redirect in the same cycle as a completing handshake in READ: discard the data, issue the new aligned PC next cycle, reload the burst count.
REQ-025 Redirect in IDLE in the same cycle as reset deassertion SHALL be honoured.
REQ-026 bus_read_ready while bus_read_vaild=0 SHALL be ignored.
REQ-027 bus_read_data SHALL be captured only on a completing handshake.
REQ-028 instruction_ready SHALL never be high for two consecutive cycles unless two reads completed back-to-back.

Reset
REQ-029 reset=0 SHALL asynchronously force: state IDLE, bus_read_vaild=0, bus_read_address=0, instruction=0, instruction_ready=0, burst count=0, stored PC=0.
REQ-030 Reset asserted mid-transaction SHALL abandon the transaction; no data from it is ever delivered.

Configuration
REQ-031 Macro FETCH_PREFETCH_EN defined: sequential prefetch of up to MAX_BURST words per redirect (REQ-019).
REQ-032 Macro FETCH_PREFETCH_EN undefined: exactly one word is fetched per redirect, and MAX_BURST is ignored.

Structure
REQ-033 Package fetch_pkg SHALL hold the FSM state enum (IDLE, READ, DRAIN), the constant WORD_BYTES=4 and the 32-bit address typedef.
REQ-034 fetch SHALL be a single module with no sub-modules.

Verification
REQ-035 Reset low, then high; PC=0x0000_0020 valid for 2 cycles; ready=0 for 4 cycles -> bus_read_vaild=1 with address held at 0x0000_0020 throughout, and no instruction_ready.
REQ-036 Continuing REQ-035, ready=1 with data=0x0001_1011 held -> instruction=0x0001_1011 pulses each cycle; addresses 0x20, 0x24, ... 0x3C; bus_read_vaild drops after the 8th word (prefetch on).
REQ-037 PC=0x0000_0103 -> first address 0x0000_0100.
REQ-038 PC=0xFFFF_FFF8 with prefetch on, ready=1 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-039 Redirect to 0x0000_0200 while a read of 0x0000_0024 is stalled, then ready=1 -> the 0x24 data is not delivered (no pulse); next address is 0x0000_0200.
REQ-040 Reset pulse while bus_read_vaild=1 -> all outputs are 0 immediately, and there is no instruction_ready after release.
REQ-041 Prefetch off, PC=0x40, ready=1 -> exactly one instruction_ready pulse, then bus_read_vaild=0.
